// File: rtl/axi_read_arbiter.sv
// Two-requester AXI read arbiter: core (0) and VGA fetcher (1) share one slave read port.
// One burst in flight; round-robin ties with an urgent override for requester 1.
module axi_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  m0_arvalid,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic [LEN_WIDTH-1:0]  m0_arlen,
  output logic                  m0_arready,
  output logic                  m0_rvalid,
  output logic                  m0_rlast,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m0_rready,

  input  logic                  m1_arvalid,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic [LEN_WIDTH-1:0]  m1_arlen,
  output logic                  m1_arready,
  output logic                  m1_rvalid,
  output logic                  m1_rlast,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  input  logic                  m1_rready,
  input  logic                  m1_urgent,

  output logic                  s_arvalid,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic [LEN_WIDTH-1:0]  s_arlen,
  input  logic                  s_arready,
  input  logic                  s_rvalid,
  input  logic                  s_rlast,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  s_rready,

  output logic                  protocol_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  perr_q, perr_d;

  logic winner;
  logic any_req;
  logic cnt_zero;
  logic sel_rready;
  logic r_hs;

  assign any_req    = m0_arvalid | m1_arvalid;
  assign cnt_zero   = (cnt_q == '0);
  assign sel_rready = grant_q ? m1_rready : m0_rready;
  assign r_hs       = (state_q == DATA) && s_rvalid && sel_rready;

  // Urgent display fetch beats fairness; otherwise ties alternate.
  always_comb begin
    winner = 1'b0;
    if (m1_arvalid && m1_urgent) begin
      winner = 1'b1;
    end else if (m0_arvalid && m1_arvalid) begin
      winner = ~last_grant_q;
    end else begin
      winner = m1_arvalid;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      perr_q       <= perr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    perr_d       = perr_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d      = winner;
          last_grant_d = winner;
          addr_d       = winner ? m1_araddr : m0_araddr;
          len_d        = winner ? m1_arlen  : m0_arlen;
          cnt_d        = winner ? m1_arlen  : m0_arlen;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        if (s_arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
          // The local beat count is authoritative; a disagreeing s_rlast is only flagged.
          if (s_rlast != cnt_zero) begin
            perr_d = 1'b1;
          end
          if (cnt_zero) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - LEN_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    s_arvalid  = 1'b0;
    s_araddr   = addr_q;
    s_arlen    = len_q;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rlast   = 1'b0;
    m0_rdata   = '0;
    m1_rvalid  = 1'b0;
    m1_rlast   = 1'b0;
    m1_rdata   = '0;

    if (state_q == ADDR) begin
      s_arvalid  = 1'b1;
      m0_arready = s_arready & ~grant_q;
      m1_arready = s_arready &  grant_q;
    end

    if (state_q == DATA) begin
      s_rready = sel_rready;
      if (grant_q) begin
        m1_rvalid = s_rvalid;
        m1_rlast  = cnt_zero;
        m1_rdata  = s_rdata;
      end else begin
        m0_rvalid = s_rvalid;
        m0_rlast  = cnt_zero;
        m0_rdata  = s_rdata;
      end
    end
  end

  assign protocol_error = perr_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: slave/master stimulus in one initial block,
// grant and beat expectations queued on drive and checked by a negedge monitor.
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rlast, m0_rready;
  logic [31:0] m0_araddr, m0_rdata;
  logic [7:0]  m0_arlen;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rlast, m1_rready, m1_urgent;
  logic [31:0] m1_araddr, m1_rdata;
  logic [7:0]  m1_arlen;
  logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready, protocol_error;
  logic [31:0] s_araddr, s_rdata;
  logic [7:0]  s_arlen;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        who;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic  gq[$];
  beat_t bq[$];

  axi_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast), .m0_rdata(m0_rdata), .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast), .m1_rdata(m1_rdata), .m1_rready(m1_rready),
    .m1_urgent(m1_urgent),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rdata(s_rdata), .s_rready(s_rready),
    .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    #1;
    chk(tag, 64'({s_arvalid, m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_rready, protocol_error}), 64'd0);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick;
    tick;
    chk_zero("reset_outputs");
    reset = 1'b1;
    tick;
  endtask

  // mode: 0 drop granted arvalid, 1 keep both, 2 drop both, 3 keep both and clear urgent
  task automatic do_burst(input logic who, input logic [31:0] addr, input logic [7:0] len,
                          input int ar_delay, input logic [31:0] base, input int bad_idx,
                          input bit toggle, input int mode, input int abort_at);
    int  w;
    int  n;
    bit  phase;
    bit  done;
    logic rr;
    n = int'(len) + 1;
    w = 0;
    while (s_arvalid !== 1'b1 && w < 20) begin
      tick;
      w++;
    end
    chk("ar_latency", 64'(w), 64'd1);
    if (s_arvalid !== 1'b1) return;
    chk("s_araddr", 64'(s_araddr), 64'(addr));
    chk("s_arlen", 64'(s_arlen), 64'(len));
    for (int d = 0; d < ar_delay; d++) tick;
    gq.push_back(who);
    s_arready = 1'b1;
    tick;
    s_arready = 1'b0;
    chk("ar_done", 64'(s_arvalid), 64'd0);
    case (mode)
      0: if (who) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
      2: begin m0_arvalid = 1'b0; m1_arvalid = 1'b0; end
      3: m1_urgent = 1'b0;
      default: ;
    endcase
    phase = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_rvalid = 1'b1;
      s_rdata  = base + 32'(i);
      s_rlast  = (bad_idx >= 0) ? (i == bad_idx) : (i == n - 1);
      if (i == abort_at) begin
        m0_rready = 1'b0;
        m1_rready = 1'b0;
        reset = 1'b0;
        tick;
        if (who) m1_rready = 1'b1; else m0_rready = 1'b1;
        chk_zero("abort_outputs");
        reset    = 1'b1;
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        tick;
        chk_zero("abort_released");
        m0_rready = 1'b0;
        m1_rready = 1'b0;
        return;
      end
      bq.push_back('{who: who, data: base + 32'(i), last: (i == n - 1)});
      done = 1'b0;
      while (!done) begin
        rr = toggle ? phase : 1'b1;
        phase = ~phase;
        if (who) m1_rready = rr; else m0_rready = rr;
        #1;
        chk("s_rready_mirror", 64'(s_rready), 64'(rr));
        tick;
        done = rr;
      end
    end
    s_rvalid  = 1'b0;
    s_rlast   = 1'b0;
    m0_rready = 1'b0;
    m1_rready = 1'b0;
    chk("beats_drained", 64'(bq.size()), 64'd0);
    chk("grants_drained", 64'(gq.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    logic  g;
    beat_t b;
    logic  obs_who;
    if (m0_arready || m1_arready) begin
      chk("grant_expected", 64'(gq.size() != 0), 64'd1);
      if (gq.size() != 0) begin
        g = gq.pop_front();
        chk("grant_who", 64'({m1_arready, m0_arready}), g ? 64'd2 : 64'd1);
      end
    end
    if (s_rvalid && bq.size() != 0) begin
      chk("rvalid_route", 64'({m1_rvalid, m0_rvalid}), bq[0].who ? 64'd2 : 64'd1);
    end
    if ((m0_rvalid && m0_rready) || (m1_rvalid && m1_rready)) begin
      chk("beat_expected", 64'(bq.size() != 0), 64'd1);
      if (bq.size() != 0) begin
        b = bq.pop_front();
        obs_who = m1_rvalid && m1_rready;
        chk("beat_who", 64'(obs_who), 64'(b.who));
        chk("beat_data", 64'(obs_who ? m1_rdata : m0_rdata), 64'(b.data));
        chk("beat_last", 64'(obs_who ? m1_rlast : m0_rlast), 64'(b.last));
        $display("beat: who=%0d data=%08h last=%0d", obs_who, obs_who ? m1_rdata : m0_rdata,
                 obs_who ? m1_rlast : m0_rlast);
      end
    end
  end

  initial begin
    reset = 1'b0;
    m0_arvalid = 0; m0_araddr = 0; m0_arlen = 0; m0_rready = 0;
    m1_arvalid = 0; m1_araddr = 0; m1_arlen = 0; m1_rready = 0; m1_urgent = 0;
    s_arready = 0; s_rvalid = 0; s_rlast = 0; s_rdata = 0;
    tick; tick; tick;
    chk_zero("reset_state");
    reset = 1'b1;
    tick;

    // single m0 burst, slave accepts address after 2 cycles
    m0_araddr = 32'h1000; m0_arlen = 8'd3; m0_arvalid = 1'b1;
    do_burst(1'b0, 32'h1000, 8'd3, 2, 32'hA0, -1, 1'b0, 0, -1);
    chk("perr_clean", 64'(protocol_error), 64'd0);

    // simultaneous requests alternate 0,1,0,1
    do_reset;
    m0_araddr = 32'h2000; m0_arlen = 8'd0; m0_arvalid = 1'b1;
    m1_araddr = 32'h3000; m1_arlen = 8'd0; m1_arvalid = 1'b1;
    do_burst(1'b0, 32'h2000, 8'd0, 0, 32'hB0, -1, 1'b0, 1, -1);
    do_burst(1'b1, 32'h3000, 8'd0, 0, 32'hB1, -1, 1'b0, 1, -1);
    do_burst(1'b0, 32'h2000, 8'd0, 0, 32'hB2, -1, 1'b0, 1, -1);
    do_burst(1'b1, 32'h3000, 8'd0, 0, 32'hB3, -1, 1'b0, 2, -1);

    // urgent override: m1 twice, then m0 once urgent drops
    m0_araddr = 32'h4000; m0_arlen = 8'd1; m0_arvalid = 1'b1;
    m1_araddr = 32'h5000; m1_arlen = 8'd1; m1_arvalid = 1'b1; m1_urgent = 1'b1;
    do_burst(1'b1, 32'h5000, 8'd1, 1, 32'hC0, -1, 1'b0, 1, -1);
    do_burst(1'b1, 32'h5000, 8'd1, 0, 32'hC2, -1, 1'b0, 3, -1);
    do_burst(1'b0, 32'h4000, 8'd1, 0, 32'hC4, -1, 1'b0, 2, -1);

    // m1 eight-beat burst with rready toggling
    m1_araddr = 32'h6000; m1_arlen = 8'd7; m1_arvalid = 1'b1;
    do_burst(1'b1, 32'h6000, 8'd7, 1, 32'hD0, -1, 1'b1, 0, -1);
    chk("perr_clean2", 64'(protocol_error), 64'd0);

    // early s_rlast flags protocol_error, which is sticky
    m0_araddr = 32'h7000; m0_arlen = 8'd3; m0_arvalid = 1'b1;
    do_burst(1'b0, 32'h7000, 8'd3, 0, 32'hE0, 2, 1'b0, 0, -1);
    chk("perr_set", 64'(protocol_error), 64'd1);
    tick;
    m1_araddr = 32'h7100; m1_arlen = 8'd0; m1_arvalid = 1'b1;
    do_burst(1'b1, 32'h7100, 8'd0, 0, 32'hE8, -1, 1'b0, 0, -1);
    chk("perr_sticky", 64'(protocol_error), 64'd1);

    // reset on beat 1 abandons the burst; a new request then works
    m0_araddr = 32'h8000; m0_arlen = 8'd7; m0_arvalid = 1'b1;
    do_burst(1'b0, 32'h8000, 8'd7, 0, 32'hF0, -1, 1'b0, 0, 1);
    chk("perr_after_reset", 64'(protocol_error), 64'd0);
    chk("abort_no_pending", 64'(bq.size()), 64'd0);
    m0_araddr = 32'h9000; m0_arlen = 8'd1; m0_arvalid = 1'b1;
    do_burst(1'b0, 32'h9000, 8'd1, 0, 32'h90, -1, 1'b0, 0, -1);

    tick; tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
